// File: rtl/apb_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// apb_bus_arbiter_if
// Bundles every requester-side and APB-master-side signal of the
// two-requester APB front end.
//
// Signals:
//   m0_* / m1_*  requester ports (transfer/write/addr/wdata in,
//                rdata/ready/err out of the arbiter)
//   s_*          APB master side (transfer/write/addr/wdata out of the
//                arbiter, rdata/ready back in)
//   grant, busy  arbiter status
//
// Modports:
//   slave  - the arbiter's view. It serves the two requesters and drives
//            the APB master.
//   master - the environment's view. It holds the requesters plus the
//            APB master model.
//
// Handshake: a requester raises mX_transfer with write/addr/wdata stable
// and holds it until mX_ready pulses for one cycle. The arbiter pulses
// s_transfer for one cycle per transfer. s_ready is a one-cycle completion
// that is only honoured while a transfer is outstanding.
// ---------------------------------------------------------------------------
interface apb_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_transfer;
  logic              m0_write;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_ready;
  logic              m0_err;

  logic              m1_transfer;
  logic              m1_write;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_ready;
  logic              m1_err;

  logic              s_transfer;
  logic              s_write;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic [DATA_W-1:0] s_rdata;
  logic              s_ready;

  logic [1:0]        grant;
  logic              busy;

  modport slave (
    input  m0_transfer, m0_write, m0_addr, m0_wdata,
    output m0_rdata, m0_ready, m0_err,
    input  m1_transfer, m1_write, m1_addr, m1_wdata,
    output m1_rdata, m1_ready, m1_err,
    output s_transfer, s_write, s_addr, s_wdata,
    input  s_rdata, s_ready,
    output grant, busy
  );

  modport master (
    output m0_transfer, m0_write, m0_addr, m0_wdata,
    input  m0_rdata, m0_ready, m0_err,
    output m1_transfer, m1_write, m1_addr, m1_wdata,
    input  m1_rdata, m1_ready, m1_err,
    input  s_transfer, s_write, s_addr, s_wdata,
    output s_rdata, s_ready,
    input  grant, busy
  );
endinterface

// File: rtl/apb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// apb_bus_arbiter
// Lets the CPU (requester 0) and a DMA/debug engine (requester 1) share one
// APB master. Arbitration is round-robin and the grant is held for one
// whole transfer. A response watchdog forces an error completion when the
// peripheral never returns s_ready.
//
// Ports:
//   PCLK     bus clock
//   PRESET   asynchronous, active-low reset
//   bus      apb_bus_arbiter_if.slave (requesters, APB master, grant/busy)
//   state_o  current FSM state (IDLE=0, ISSUE=1, WAIT=2), for debug
//
// Parameters:
//   ADDR_W, DATA_W  bus widths. These must match the interface instance.
//   TIMEOUT         number of WAIT cycles without s_ready before a forced
//                   error completion. A value of 0 disables the watchdog.
// ---------------------------------------------------------------------------
module apb_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                PCLK,
  input  logic                PRESET,
  apb_bus_arbiter_if.slave    bus,
  output logic [1:0]          state_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // The counter is wide enough to hold TIMEOUT, so it reaches TIMEOUT-1
  // before it can saturate. With the watchdog disabled, one bit is kept
  // only to avoid a zero-width vector.
  localparam bit              TMO_EN   = (TIMEOUT > 0);
  localparam int              CNT_W    = TMO_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_q,  last_d;    // owner of the most recent completion
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic in_wait;
  logic resp_ok;      // peripheral answered in WAIT
  logic timeout_hit;  // watchdog fires in this WAIT cycle
  logic done;         // transfer completes this cycle

  assign in_wait     = (state_q == ST_WAIT);
  assign resp_ok     = in_wait && bus.s_ready;
  assign timeout_hit = TMO_EN && in_wait && !bus.s_ready && (cnt_q == TMO_LAST);
  assign done        = resp_ok || timeout_hit;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.m0_transfer || bus.m1_transfer) begin
          // When both requesters contend, the one that did not finish last wins.
          if (bus.m0_transfer && bus.m1_transfer) begin
            grant_d = last_q ? 2'b01 : 2'b10;
          end else begin
            grant_d = bus.m0_transfer ? 2'b01 : 2'b10;
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done) begin
          last_d  = grant_q[1];
          grant_d = 2'b00;
          state_d = ST_IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        grant_d = 2'b00;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // grant_q is non-zero only in ISSUE and WAIT. Gating the mux with it
  // keeps the master-side buses at zero in IDLE and during reset.
  assign bus.s_transfer = (state_q == ST_ISSUE);
  assign bus.s_write    = (grant_q[0] & bus.m0_write) | (grant_q[1] & bus.m1_write);
  assign bus.s_addr     = ({ADDR_W{grant_q[0]}} & bus.m0_addr)
                        | ({ADDR_W{grant_q[1]}} & bus.m1_addr);
  assign bus.s_wdata    = ({DATA_W{grant_q[0]}} & bus.m0_wdata)
                        | ({DATA_W{grant_q[1]}} & bus.m1_wdata);

  assign bus.m0_ready = done & grant_q[0];
  assign bus.m1_ready = done & grant_q[1];
  assign bus.m0_err   = timeout_hit & grant_q[0];
  assign bus.m1_err   = timeout_hit & grant_q[1];

  // Read data passes through only on a real response. A watchdog
  // completion returns zero.
  assign bus.m0_rdata = {DATA_W{resp_ok & grant_q[0]}} & bus.s_rdata;
  assign bus.m1_rdata = {DATA_W{resp_ok & grant_q[1]}} & bus.s_rdata;

  assign bus.grant = grant_q;
  assign bus.busy  = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign state_o   = state_q;

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_bus_arbiter
// Directed and randomized transfers through apb_bus_arbiter (TIMEOUT=8).
// A transaction-level model in the bench decides the winner of each
// transfer and the expected completion:
//   - round-robin on the last completed owner
//   - completion on the first WAIT cycle with s_ready
//   - otherwise an error completion on WAIT cycle TIMEOUT
// Each transfer's master-side fields go through an expected queue.
// ---------------------------------------------------------------------------
module tb_apb_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic [1:0] state_dbg;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cyc = 0;

  bit              m_last;         // model: owner of the last completion
  logic            r_write [2];
  logic [AW-1:0]   r_addr  [2];
  logic [DW-1:0]   r_wdata [2];
  logic [64:0]     exp_q[$];       // {write, addr, wdata} expected on the master side

  apb_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // ---- clock ----
  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  // ---- checking ----
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_grant"},  64'(bus.grant),      0);
    chk({tag, "_busy"},   64'(bus.busy),       0);
    chk({tag, "_strans"}, 64'(bus.s_transfer), 0);
    chk({tag, "_swrite"}, 64'(bus.s_write),    0);
    chk({tag, "_saddr"},  64'(bus.s_addr),     0);
    chk({tag, "_swdata"}, 64'(bus.s_wdata),    0);
    chk({tag, "_rdy0"},   64'(bus.m0_ready),   0);
    chk({tag, "_err0"},   64'(bus.m0_err),     0);
    chk({tag, "_rdata0"}, 64'(bus.m0_rdata),   0);
    chk({tag, "_rdy1"},   64'(bus.m1_ready),   0);
    chk({tag, "_err1"},   64'(bus.m1_err),     0);
    chk({tag, "_rdata1"}, 64'(bus.m1_rdata),   0);
  endtask

  // ---- model ----
  function automatic int exp_winner(input bit a, input bit b);
    if (a && b) return m_last ? 0 : 1;
    return a ? 0 : 1;
  endfunction

  // ---- drivers ----
  task automatic new_fields(input int i, input bit rd_only);
    r_write[i] = rd_only ? 1'b0 : 1'($urandom);
    r_addr[i]  = AW'($urandom);
    r_wdata[i] = DW'($urandom);
    if (i == 0) begin
      bus.m0_write = r_write[0]; bus.m0_addr = r_addr[0]; bus.m0_wdata = r_wdata[0];
    end else begin
      bus.m1_write = r_write[1]; bus.m1_addr = r_addr[1]; bus.m1_wdata = r_wdata[1];
    end
  endtask

  task automatic set_transfer(input int i, input bit v);
    if (i == 0) bus.m0_transfer = v;
    else        bus.m1_transfer = v;
  endtask

  // Called during an IDLE cycle, before its rising edge. The winner's
  // request is dropped after completion. The loser keeps requesting.
  task automatic run_txn(input bit rq0, input bit rq1, input int dly, input bit issue_rdy,
                         input bit late_rdy, input logic [DW-1:0] rd, output int w);
    logic [64:0]   exp_s;
    bit            hit, tmo, fin;
    logic          rdy_w, err_w, rdy_o, err_o;
    logic [DW-1:0] rdata_w, rdata_o;
    w = exp_winner(rq0, rq1);
    bus.m0_transfer = rq0;
    bus.m1_transfer = rq1;
    exp_q.push_back({r_write[w], r_addr[w], r_wdata[w]});
    @(posedge PCLK); #1;
    bus.s_ready = issue_rdy;
    bus.s_rdata = DW'($urandom);
    @(negedge PCLK);
    exp_s = exp_q.pop_front();
    chk("issue_pulse", 64'(bus.s_transfer), 1);
    chk("issue_grant", 64'(bus.grant), (w == 0) ? 2 'b01 : 2'b10);
    chk("issue_busy",  64'(bus.busy), 1);
    chk("issue_write", 64'(bus.s_write), 64'(exp_s[64]));
    chk("issue_addr",  64'(bus.s_addr),  64'(exp_s[63:32]));
    chk("issue_wdata", 64'(bus.s_wdata), 64'(exp_s[31:0]));
    chk("issue_rdy0",  64'(bus.m0_ready), 0);
    chk("issue_rdy1",  64'(bus.m1_ready), 0);
    fin = 1'b0;
    for (int k = 0; k < TO && !fin; k++) begin
      @(posedge PCLK); #1;
      hit = (dly == k);
      bus.s_ready = hit;
      bus.s_rdata = hit ? rd : DW'($urandom);
      @(negedge PCLK);
      tmo = !hit && (k == TO - 1);
      fin = hit || tmo;
      rdy_w   = (w == 0) ? bus.m0_ready : bus.m1_ready;
      err_w   = (w == 0) ? bus.m0_err   : bus.m1_err;
      rdata_w = (w == 0) ? bus.m0_rdata : bus.m1_rdata;
      rdy_o   = (w == 0) ? bus.m1_ready : bus.m0_ready;
      err_o   = (w == 0) ? bus.m1_err   : bus.m0_err;
      rdata_o = (w == 0) ? bus.m1_rdata : bus.m0_rdata;
      chk("wait_pulse",  64'(bus.s_transfer), 0);
      chk("wait_grant",  64'(bus.grant), (w == 0) ? 2'b01 : 2'b10);
      chk("wait_busy",   64'(bus.busy), 1);
      chk("wait_addr",   64'(bus.s_addr), 64'(exp_s[63:32]));
      chk("wait_ready",  64'(rdy_w), 64'(fin));
      chk("wait_err",    64'(err_w), 64'(tmo));
      if (fin) chk("done_rdata", 64'(rdata_w), 64'(hit ? rd : {DW{1'b0}}));
      chk("other_ready", 64'(rdy_o), 0);
      chk("other_err",   64'(err_o), 0);
      chk("other_rdata", 64'(rdata_o), 0);
    end
    m_last   = (w == 1);
    done_cyc = cyc;
    @(posedge PCLK); #1;
    set_transfer(w, 1'b0);
    bus.s_ready = late_rdy;
    bus.s_rdata = DW'($urandom);
    @(negedge PCLK);
    check_idle("idle_after");
  endtask

  // ---- stimulus ----
  initial begin
    int            w;
    int            prev_done;
    logic [DW-1:0] rd;
    bit [1:0]      pend;
    bit            rq [2];

    PRESET = 1'b0;
    bus.m0_transfer = 0; bus.m0_write = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_transfer = 0; bus.m1_write = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
    bus.s_ready = 0; bus.s_rdata = '0;
    m_last = 1'b1;
    #1;
    check_idle("reset");
    repeat (2) @(negedge PCLK);
    PRESET = 1'b1;
    @(negedge PCLK);
    check_idle("post_reset");

    // m0 write, s_ready two cycles after s_transfer
    r_write[0] = 1'b1; r_addr[0] = 32'h1000_0000; r_wdata[0] = 32'h0000_00A5;
    bus.m0_write = 1'b1; bus.m0_addr = 32'h1000_0000; bus.m0_wdata = 32'h0000_00A5;
    run_txn(1, 1, 1, 0, 0, '0, w);
    bus.m1_transfer = 1'b0;
    // The write above ran with both requesting: m0 wins after reset.
    chk("first_winner_m0", 64'(w), 0);

    // both requesters read continuously, grants alternate
    new_fields(0, 1); new_fields(1, 1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) new_fields(w, 1);
      rd = (exp_winner(1, 1) == 0) ? 32'h11 : 32'h22;
      run_txn(1, 1, $urandom_range(0, 3), 0, 0, rd, w);
    end
    bus.m0_transfer = 1'b0; bus.m1_transfer = 1'b0;

    // m1 alone, four back-to-back reads
    prev_done = 0;
    for (int i = 0; i < 4; i++) begin
      new_fields(1, 1);
      run_txn(0, 1, $urandom_range(0, 3), 0, 0, DW'($urandom), w);
      if (i > 0) chk("m1_spacing", 64'(done_cyc - prev_done >= 3), 1);
      prev_done = done_cyc;
    end

    // watchdog: m0 never answered, m1 pending gets the next grant, late s_ready ignored
    new_fields(0, 0); new_fields(1, 0);
    run_txn(1, 1, TO + 5, 0, 1, '0, w);
    run_txn(0, 1, 2, 0, 0, DW'($urandom), w);

    // s_ready during ISSUE is ignored
    new_fields(0, 0);
    run_txn(1, 0, 2, 1, 0, DW'($urandom), w);

    // asynchronous reset during WAIT
    new_fields(0, 0);
    bus.m0_transfer = 1'b1;
    @(posedge PCLK); #1;
    bus.s_ready = 1'b0;
    @(posedge PCLK); #2;
    PRESET = 1'b0;
    bus.s_ready = 1'b1;
    bus.s_rdata = DW'($urandom);
    #1;
    check_idle("rst_async");
    @(posedge PCLK); #1;
    bus.m0_transfer = 1'b0;
    @(negedge PCLK);
    check_idle("rst_hold");
    #2;
    PRESET = 1'b1;
    m_last = 1'b1;
    @(posedge PCLK); #1;
    @(negedge PCLK);
    check_idle("rst_late_rdy");
    new_fields(0, 0); new_fields(1, 0);
    run_txn(1, 1, 1, 0, 0, DW'($urandom), w);
    bus.m1_transfer = 1'b0;

    // randomized traffic; a losing requester keeps its request and fields
    pend = 2'b00;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 2; i++) begin
        rq[i] = pend[i] | 1'($urandom);
      end
      if (!rq[0] && !rq[1]) rq[$urandom_range(0, 1)] = 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (rq[i] && !pend[i]) new_fields(i, 0);
      end
      run_txn(rq[0], rq[1], $urandom_range(0, 10), 1'($urandom), 1'($urandom),
              DW'($urandom), w);
      pend[0] = rq[0] && (w != 0);
      pend[1] = rq[1] && (w != 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // watchdog on the bench itself
  initial begin
    #200000;
    $display("FAIL bench_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/apb_bus_arbiter.md
Name: apb_bus_arbiter

Overview:
Two-requester front end for the single APB master, so the CPU (requester 0) and a DMA/debug engine (requester 1) can share the peripheral bus (RAM, GPO, GPI, GPIO, UART).
- Arbitrates round-robin and holds the grant for one whole transfer.
- Presents the APB master with a single-cycle transfer pulse plus write/addr/wdata, and returns ready/rdata to the granted requester only.
- Contains a response watchdog so a peripheral that never returns PREADY cannot hang both requesters.

Parameters:
ADDR_W, 32, address width of requester and master-side buses
DATA_W, 32, data width
TIMEOUT, 255, WAIT cycles without s_ready before forced error completion; 0 disables the watchdog

Ports:
PCLK  input  1  bus clock
PRESET  input  1  asynchronous, active-low reset
m0_transfer  input  1  requester 0 request level; held high with m0_write/addr/wdata stable until m0_ready
m0_write  input  1  requester 0 write (1) / read (0)
m0_addr  input  ADDR_W  requester 0 address
m0_wdata  input  DATA_W  requester 0 write data
m0_rdata  output  DATA_W  requester 0 read data, valid while m0_ready=1
m0_ready  output  1  requester 0 one-cycle completion
m0_err  output  1  requester 0 timeout flag, coincident with m0_ready
m1_transfer, m1_write, m1_addr, m1_wdata, m1_rdata, m1_ready, m1_err  (same widths and meaning for requester 1)
s_transfer  output  1  one-cycle start pulse to APB master
s_write  output  1  to APB master
s_addr  output  ADDR_W  to APB master
s_wdata  output  DATA_W  to APB master
s_rdata  input  DATA_W  from APB master, valid with s_ready
s_ready  input  1  one-cycle completion from APB master
grant  output  2  one-hot current owner, 2'b00 when idle
busy  output  1  high in ISSUE and WAIT

Behaviour:
- Reset (PRESET=0, async): state=IDLE, grant=00, last=1, timeout counter=0. All outputs are 0: s_transfer, s_write, s_addr, s_wdata, m*_ready, m*_err, m*_rdata, busy.
- Reset asserted mid-transfer aborts it with no ready or err to either requester. A late s_ready after reset is ignored.
- State IDLE, no request: stay in IDLE.
- State IDLE, single request: grant that requester; next state ISSUE.
- State IDLE, both requesting: grant the requester not equal to last. After reset requester 0 wins first.
- State ISSUE: s_transfer=1 for exactly one cycle; next state WAIT; counter cleared.
- State WAIT, s_ready=1: m{g}_ready=1 and m{g}_rdata=s_rdata, combinational in the same cycle. last=g; next state IDLE.
- State WAIT, s_ready=0: counter+1.
- State WAIT, counter==TIMEOUT-1 (TIMEOUT>0) with s_ready=0: m{g}_ready=1, m{g}_err=1, m{g}_rdata=0. last=g; next state IDLE.
- s_write/s_addr/s_wdata are muxed from the granted requester in ISSUE and WAIT, and are 0 in IDLE.
- Non-granted requester outputs are always 0.
- s_ready outside WAIT, including in ISSUE, is ignored.
- Minimum latency from request in IDLE at cycle N: s_transfer at N+1, earliest ready at N+2. One idle cycle between back-to-back transfers.
- A requester dropping transfer before its ready: the arbiter still completes the transfer and pulses ready. This is a requester protocol violation; no abort path exists.
- Counter width is clog2(TIMEOUT+1); the counter saturates and never wraps.
- A same-cycle new request while completing in WAIT is sampled on the following IDLE cycle.

Test Plan:
- Reset then m0 write addr=0x1000_0000 wdata=0xA5 with s_ready 2 cycles after s_transfer -> s_transfer single pulse at N+1, s_addr=0x1000_0000, s_write=1, m0_ready one cycle, m1_ready=0, grant=01 then 00.
- m0 and m1 both request reads continuously; master returns s_rdata=0x11 then 0x22 -> grants alternate 01,10,01,10 starting with m0; m0_rdata=0x11, m1_rdata=0x22.
- m1 alone does 4 back-to-back reads -> each granted; m1_ready spacing ≥3 cycles; m0 outputs stay 0.
- TIMEOUT=8, s_ready never asserted -> m0_ready=m0_err=1 exactly 8 WAIT cycles after ISSUE, m0_rdata=0. A pending m1 request is granted next; a late s_ready in IDLE is ignored.
- PRESET pulsed low during WAIT -> all outputs 0 immediately (async). After release, grant resumes with m0 priority; no stale ready is issued.
- s_ready asserted during ISSUE cycle -> ignored; completion occurs only on a subsequent WAIT-cycle s_ready.
